// File: rtl/sync_edge_event.sv
// sync_edge_event: debounces a level that has already been brought into the dstclk
// domain. It reports the accepted level, produces one-cycle edge pulses and keeps a
// saturating count of the edges whose direction is enabled.
//
// Ports
//   dstclk        in   destination clock; every register updates on its rising edge
//   dstreset      in   asynchronous active-high reset
//   syncdata      in   resynchronised input level
//   riseen        in   count accepted 0->1 transitions
//   fallen        in   count accepted 1->0 transitions
//   eventclear    in   clear the counter and the overflow flag at the next edge
//   filtlevel     out  debounced level
//   risepulse     out  one-cycle pulse in the first cycle filtlevel shows 1
//   fallpulse     out  one-cycle pulse in the first cycle filtlevel shows 0
//   eventcount    out  saturating count of enabled edges
//   eventpending  out  eventcount is non-zero
//   overflow      out  sticky flag: an enabled edge arrived while the count was all-ones
module sync_edge_event #(
   parameter int unsigned FILTER_CYCLES = 3,
   parameter int unsigned CNT_WIDTH     = 8,
   parameter bit          RESET_LEVEL   = 1'b0
) (
   input  logic                 dstclk,
   input  logic                 dstreset,
   input  logic                 syncdata,
   input  logic                 riseen,
   input  logic                 fallen,
   input  logic                 eventclear,
   output logic                 filtlevel,
   output logic                 risepulse,
   output logic                 fallpulse,
   output logic [CNT_WIDTH-1:0] eventcount,
   output logic                 eventpending,
   output logic                 overflow
);

   localparam logic [3:0]           FcntLast = 4'(FILTER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [3:0]           fcnt_q, fcnt_d;
   logic                 level_d;
   logic                 accept;
   logic                 rise_d, fall_d;
   logic                 event_hit;
   logic [CNT_WIDTH-1:0] count_d;
   logic                 ovf_d;

   always_comb begin
      accept  = 1'b0;
      fcnt_d  = 4'd0;
      level_d = filtlevel;
      // The filter counter runs only while the input disagrees with the accepted
      // level; any cycle of agreement throws away the partial run.
      if (syncdata != filtlevel) begin
         if (fcnt_q == FcntLast) begin
            accept  = 1'b1;
            level_d = syncdata;
         end else begin
            fcnt_d = fcnt_q + 4'd1;
         end
      end

      rise_d    = accept & ~filtlevel;
      fall_d    = accept & filtlevel;
      // Enables are looked at only in the cycle the transition is accepted.
      event_hit = (rise_d & riseen) | (fall_d & fallen);

      count_d = eventcount;
      ovf_d   = overflow;
      if (eventclear) begin
         // A clear that coincides with an event still counts that event.
         count_d = event_hit ? CntOne : '0;
         ovf_d   = 1'b0;
      end else if (event_hit) begin
         if (eventcount == CntMax) begin
            ovf_d = 1'b1;
         end else begin
            count_d = eventcount + CntOne;
         end
      end
   end

   always_ff @(posedge dstclk or posedge dstreset) begin
      if (dstreset) begin
         fcnt_q     <= 4'd0;
         filtlevel  <= RESET_LEVEL;
         risepulse  <= 1'b0;
         fallpulse  <= 1'b0;
         eventcount <= '0;
         overflow   <= 1'b0;
      end else begin
         fcnt_q     <= fcnt_d;
         filtlevel  <= level_d;
         risepulse  <= rise_d;
         fallpulse  <= fall_d;
         eventcount <= count_d;
         overflow   <= ovf_d;
      end
   end

   assign eventpending = |eventcount;

endmodule

// File: tb/tb_sync_edge_event.sv
// Randomised plus directed bench for sync_edge_event. Two instances share one stimulus
// stream: A uses the default parameters, B uses FILTER_CYCLES=1, CNT_WIDTH=2 and
// RESET_LEVEL=1 so saturation and the opposite reset level are exercised. Each
// instance has its own reference model and expectation queue; a monitor pops and
// compares after every clock edge.
module tb_sync_edge_event;

   localparam int FcA = 3;
   localparam int CwA = 8;
   localparam bit RlA = 1'b0;
   localparam int FcB = 1;
   localparam int CwB = 2;
   localparam bit RlB = 1'b1;

   typedef struct {
      bit level;
      int run;   // consecutive cycles the input has disagreed since the last acceptance
      bit rp;
      bit fp;
      int cnt;
      bit ovf;
   } model_t;

   logic       dstclk = 1'b0;
   logic       dstreset;
   logic       syncdata, riseen, fallen, eventclear;
   logic       lvl_a, rp_a, fp_a, pend_a, ovf_a;
   logic [7:0] cnt_a;
   logic       lvl_b, rp_b, fp_b, pend_b, ovf_b;
   logic [1:0] cnt_b;

   model_t m_a, m_b;
   model_t q_a[$];
   model_t q_b[$];
   int     n_vec  = 0;
   int     n_fail = 0;

   always #5 dstclk = ~dstclk;

   sync_edge_event #(
      .FILTER_CYCLES(FcA),
      .CNT_WIDTH    (CwA),
      .RESET_LEVEL  (RlA)
   ) u_dut_a (
      .dstclk      (dstclk),
      .dstreset    (dstreset),
      .syncdata    (syncdata),
      .riseen      (riseen),
      .fallen      (fallen),
      .eventclear  (eventclear),
      .filtlevel   (lvl_a),
      .risepulse   (rp_a),
      .fallpulse   (fp_a),
      .eventcount  (cnt_a),
      .eventpending(pend_a),
      .overflow    (ovf_a)
   );

   sync_edge_event #(
      .FILTER_CYCLES(FcB),
      .CNT_WIDTH    (CwB),
      .RESET_LEVEL  (RlB)
   ) u_dut_b (
      .dstclk      (dstclk),
      .dstreset    (dstreset),
      .syncdata    (syncdata),
      .riseen      (riseen),
      .fallen      (fallen),
      .eventclear  (eventclear),
      .filtlevel   (lvl_b),
      .risepulse   (rp_b),
      .fallpulse   (fp_b),
      .eventcount  (cnt_b),
      .eventpending(pend_b),
      .overflow    (ovf_b)
   );

   // Behavioural model: the level flips once the input has disagreed for fc cycles
   // in a row; the count is a saturating integer.
   function automatic model_t mstep(model_t s, int fc, int cw, bit rl,
                                    bit rst, bit d, bit re, bit fe, bit clr);
      model_t n;
      bit     acc, ev;
      n = s;
      if (rst) begin
         n.level = rl; n.run = 0; n.rp = 0; n.fp = 0; n.cnt = 0; n.ovf = 0;
         return n;
      end
      acc = 1'b0;
      if (d != s.level) begin
         n.run = s.run + 1;
         if (n.run == fc) begin
            acc   = 1'b1;
            n.run = 0;
         end
      end else begin
         n.run = 0;
      end
      n.rp = acc && (d == 1'b1);
      n.fp = acc && (d == 1'b0);
      ev   = (n.rp && re) || (n.fp && fe);
      if (acc) n.level = d;
      if (clr) begin
         n.cnt = ev ? 1 : 0;
         n.ovf = 1'b0;
      end else if (ev) begin
         if (s.cnt == (1 << cw) - 1) n.ovf = 1'b1;
         else n.cnt = s.cnt + 1;
      end
      return n;
   endfunction

   task automatic drive(bit rst, bit d, bit re, bit fe, bit clr);
      @(negedge dstclk);
      dstreset   = rst;
      syncdata   = d;
      riseen     = re;
      fallen     = fe;
      eventclear = clr;
      m_a = mstep(m_a, FcA, CwA, RlA, rst, d, re, fe, clr);
      m_b = mstep(m_b, FcB, CwB, RlB, rst, d, re, fe, clr);
      q_a.push_back(m_a);
      q_b.push_back(m_b);
   endtask

   task automatic chk(string name, int act, int exp);
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are fully registered, so sample shortly after each edge.
   initial begin
      model_t e;
      forever begin
         @(posedge dstclk);
         #1;
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_vec++;
            chk("a.filtlevel", int'(lvl_a), int'(e.level));
            chk("a.risepulse", int'(rp_a), int'(e.rp));
            chk("a.fallpulse", int'(fp_a), int'(e.fp));
            chk("a.eventcount", int'(cnt_a), e.cnt);
            chk("a.eventpending", int'(pend_a), int'(e.cnt != 0));
            chk("a.overflow", int'(ovf_a), int'(e.ovf));
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_vec++;
            chk("b.filtlevel", int'(lvl_b), int'(e.level));
            chk("b.risepulse", int'(rp_b), int'(e.rp));
            chk("b.fallpulse", int'(fp_b), int'(e.fp));
            chk("b.eventcount", int'(cnt_b), e.cnt);
            chk("b.eventpending", int'(pend_b), int'(e.cnt != 0));
            chk("b.overflow", int'(ovf_b), int'(e.ovf));
         end
      end
   end

   initial begin
      bit d;
      dstreset = 1'b1; syncdata = 1'b0; riseen = 1'b0; fallen = 1'b0; eventclear = 1'b0;
      m_a = '{level: RlA, run: 0, rp: 0, fp: 0, cnt: 0, ovf: 0};
      m_b = '{level: RlB, run: 0, rp: 0, fp: 0, cnt: 0, ovf: 0};

      // Reset state, then a clean rising edge held long with riseen=1.
      repeat (3) drive(1, 0, 1, 0, 0);
      repeat (9) drive(0, 0, 1, 0, 0);
      repeat (6) drive(0, 1, 1, 0, 0);
      // Glitches of 2 and 1 cycles against a level of 1.
      repeat (2) drive(0, 0, 1, 0, 0);
      repeat (4) drive(0, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      repeat (4) drive(0, 1, 1, 0, 0);
      // Falling edge with eventclear in the cycle A accepts it (third low cycle).
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      repeat (3) drive(0, 0, 0, 1, 0);
      // Saturation: rising edges only counted, B wraps to all-ones then overflows.
      for (int i = 0; i < 5; i++) begin
         repeat (4) drive(0, 1, 1, 0, 0);
         repeat (4) drive(0, 0, 1, 0, 0);
      end
      drive(0, 0, 1, 0, 1);
      repeat (2) drive(0, 0, 0, 0, 0);
      // riseen=0, fallen=1 over a full 0->1->0 cycle.
      repeat (4) drive(0, 1, 0, 1, 0);
      repeat (4) drive(0, 0, 0, 1, 0);
      // Reset part-way through a 0->1 filter run, input held high afterwards.
      repeat (2) drive(0, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 0);
      repeat (5) drive(0, 1, 1, 1, 0);

      // Random phase: input tends to hold, occasional glitches, clears and resets.
      d = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) d = ~d;
         drive(($urandom_range(0, 249) == 0), d, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 15) == 0));
      end

      drive(0, d, 0, 0, 0);
      @(posedge dstclk);
      #2;
      chk("queue_drained", q_a.size() + q_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_edge_event.md
SYNC_EDGE_EVENT -- requirements
Module: sync_edge_event

Interface
REQ-001 The module SHALL have parameter FILTER_CYCLES, default 3, giving the number of consecutive cycles (legal 1..15) a new input level must hold before acceptance.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, giving the event counter width (legal 2..16).
REQ-003 The module SHALL have parameter RESET_LEVEL, default 0, giving the filtered level loaded at reset.
REQ-004 dstclk  input  1  destination clock; the only clock; all state updates on its rising edge.
REQ-005 dstreset  input  1  asynchronous, active-high reset.
REQ-006 syncdata  input  1  level already resynchronised into the dstclk domain by the two-flop synchroniser stage directly upstream.
REQ-007 riseen  input  1  enables counting of filtered rising edges.
REQ-008 fallen  input  1  enables counting of filtered falling edges.
REQ-009 eventclear  input  1  single-cycle request to clear counter and overflow.
REQ-010 filtlevel  output  1  debounced level.
REQ-011 risepulse  output  1  one-cycle pulse on accepted 0->1 transition, ungated by riseen.
REQ-012 fallpulse  output  1  one-cycle pulse on accepted 1->0 transition, ungated by fallen.
REQ-013 eventcount  output  CNT_WIDTH  saturating count of enabled edges.
REQ-014 eventpending  output  1  high when eventcount is non-zero.
REQ-015 overflow  output  1  sticky; set when an enabled edge arrives while eventcount is all-ones.

Function
REQ-016 Filter: internal counter fcnt (4 bits) SHALL reset to 0 in any cycle where syncdata equals filtlevel, and increment in any cycle where they differ.
REQ-017 When syncdata differs from filtlevel and fcnt equals FILTER_CYCLES-1, filtlevel SHALL toggle at that clock edge and fcnt SHALL return to 0.
REQ-018 Latency: if syncdata first differs in cycle k and holds, filtlevel SHALL show the new level from cycle k+FILTER_CYCLES; FILTER_CYCLES=1 gives one-cycle latency.
REQ-019 A syncdata excursion shorter than FILTER_CYCLES cycles SHALL leave filtlevel, pulses and counter unchanged.
REQ-020 risepulse (fallpulse) SHALL be registered and high exactly in the first cycle filtlevel shows 1 (0), never longer than one cycle.
REQ-021 An enabled event SHALL be defined as a filtlevel transition whose direction enable (riseen or fallen) was high in the cycle the transition edge occurred.
REQ-022 On an enabled event, eventcount SHALL increment by 1 at the same clock edge that updates filtlevel; at all-ones it SHALL hold and overflow SHALL set.
REQ-023 eventclear high SHALL zero eventcount and overflow at the next edge.
REQ-024 Simultaneous eventclear and enabled event: eventcount SHALL become 1 and overflow 0.
REQ-025 eventpending SHALL be combinational from eventcount (no extra latency).
REQ-026 Enables changing mid-filter SHALL affect only the cycle the transition is accepted.

Reset
REQ-027 While dstreset is high: filtlevel = RESET_LEVEL, fcnt = 0, risepulse = fallpulse = 0, eventcount = 0, overflow = 0, eventpending = 0.
REQ-028 Reset asserted mid-filter SHALL abandon the pending transition; after release, a syncdata level differing from RESET_LEVEL SHALL require a full FILTER_CYCLES cycles.
REQ-029 No pulse SHALL be generated by reset assertion or release.

Verification
REQ-030 Defaults, riseen=1: syncdata 0->1 at cycle 10, held -> filtlevel=1 and risepulse=1 in cycle 13 only, eventcount=1, eventpending=1.
REQ-031 Glitch: syncdata high for 2 cycles, FILTER_CYCLES=3 -> filtlevel stays 0, no pulse, eventcount=0.
REQ-032 Saturation, CNT_WIDTH=2: 4 enabled rising edges -> eventcount=3, overflow=1; eventclear -> eventcount=0, overflow=0 next cycle.
REQ-033 eventclear coincident with enabled falling edge (fallen=1) -> eventcount=1, overflow=0, fallpulse=1.
REQ-034 riseen=0, fallen=1: full 0->1->0 cycle -> risepulse and fallpulse each once, eventcount=1.
REQ-035 dstreset pulsed at fcnt=2 during a 0->1 transition -> filtlevel=0 and no pulse; filtlevel=1 only 3 cycles after release with syncdata held high.
